// File: rtl/nco_ctrl_pkg.sv
// Shared types and constants for the NCO frequency-sweep sequencer.
package nco_ctrl_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int CNT_W_DEF   = 16;
  localparam int DWELL_W_DEF = 16;

  localparam logic [1:0] MODE_SINGLE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable dwell down-counter; flags the last cycle of each point and
// auto-reloads so consecutive points follow with no gap. Dwell 0 acts as 1.
module nco_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               run_i,
  output logic               tc_o
);

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] period;
  logic [DWELL_W-1:0] dwell_eff;

  assign dwell_eff = (dwell_i == '0) ? ONE : dwell_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      period <= '0;
    end else if (load_i) begin
      cnt    <= dwell_eff;
      period <= dwell_eff;
    end else if (run_i) begin
      if (cnt <= ONE)
        cnt <= period;
      else
        cnt <= cnt - ONE;
    end
  end

  assign tc_o = run_i && (cnt <= ONE);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer feeding the CORDIC NCO phase increment:
// single chirp, repeating sawtooth or triangle up/down.
//
//   state     | meaning
//   ST_IDLE   | waiting for start_i, NCO disabled
//   ST_RUN    | presenting current point to the NCO
//   ST_FINISH | one-cycle done pulse after a single sweep
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [1:0]         mode_i,
  input  logic [PHASE_W-1:0] f_start_i,
  input  logic [PHASE_W-1:0] f_step_i,
  input  logic [CNT_W-1:0]   n_points_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               val_o,
  output logic [PHASE_W-1:0] phase_inc_o,
  output logic [CNT_W-1:0]   step_idx_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic               launch;
  logic               tc;
  logic               at_end;
  logic               continuous;

  logic [1:0]         mode_q;
  logic [PHASE_W-1:0] fstart_q;
  logic [PHASE_W-1:0] fstep_q;
  logic [CNT_W-1:0]   nlast_q;
  logic               down_q;
  logic [PHASE_W-1:0] phase_q;
  logic [CNT_W-1:0]   idx_q;

  nco_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (launch),
    .dwell_i (dwell_i),
    .run_i   (state_q == ST_RUN),
    .tc_o    (tc)
  );

  assign at_end     = down_q ? (idx_q == '0) : (idx_q == nlast_q);
  assign continuous = (mode_q == MODE_REPEAT) || (mode_q == MODE_TRIANGLE);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = ST_RUN;
          launch  = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_i)
          state_d = ST_IDLE;
        else if (tc && at_end && !continuous)
          state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Point/direction datapath; phase arithmetic wraps modulo 2^PHASE_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q   <= '0;
      fstart_q <= '0;
      fstep_q  <= '0;
      nlast_q  <= '0;
      down_q   <= 1'b0;
      phase_q  <= '0;
      idx_q    <= '0;
    end else if (launch) begin
      mode_q   <= mode_i;
      fstart_q <= f_start_i;
      fstep_q  <= f_step_i;
      nlast_q  <= (n_points_i == '0) ? '0 : n_points_i - CNT_ONE;
      down_q   <= 1'b0;
      phase_q  <= f_start_i;
      idx_q    <= '0;
    end else if ((state_q == ST_RUN) && !abort_i && tc) begin
      if (!at_end) begin
        phase_q <= down_q ? phase_q - fstep_q : phase_q + fstep_q;
        idx_q   <= down_q ? idx_q - CNT_ONE : idx_q + CNT_ONE;
      end else if (mode_q == MODE_REPEAT) begin
        phase_q <= fstart_q;
        idx_q   <= '0;
      end else if ((mode_q == MODE_TRIANGLE) && (nlast_q != '0)) begin
        // reverse and move one point inward so endpoints are not repeated
        down_q  <= !down_q;
        phase_q <= down_q ? phase_q + fstep_q : phase_q - fstep_q;
        idx_q   <= down_q ? idx_q + CNT_ONE : idx_q - CNT_ONE;
      end
    end
  end

  assign val_o       = (state_q == ST_RUN);
  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_FINISH);
  assign phase_inc_o = phase_q;
  assign step_idx_o  = idx_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed and random sweeps
// compared against a closed-form point/index model.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [1:0]  mode;
  logic [15:0] f_start, f_step, n_points, dwell;
  logic        val, busy, done;
  logic [15:0] phase_inc, step_idx;

  int checks   = 0;
  int failures = 0;

  nco_sweep_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .mode_i      (mode),
    .f_start_i   (f_start),
    .f_step_i    (f_step),
    .n_points_i  (n_points),
    .dwell_i     (dwell),
    .val_o       (val),
    .phase_inc_o (phase_inc),
    .step_idx_o  (step_idx),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic b, input logic d,
                         input logic [15:0] ph, input logic [15:0] ix);
    chk({tag, ".val"},   {31'd0, val},  {31'd0, v});
    chk({tag, ".busy"},  {31'd0, busy}, {31'd0, b});
    chk({tag, ".done"},  {31'd0, done}, {31'd0, d});
    chk({tag, ".phase"}, {16'd0, phase_inc}, {16'd0, ph});
    chk({tag, ".idx"},   {16'd0, step_idx},  {16'd0, ix});
  endtask

  // index of the k-th point visited, from the sweep shape alone
  function automatic int exp_idx(input logic [1:0] m, input int n, input int k);
    int per, r;
    if (m == 2'd2) begin
      if (n == 1) return 0;
      per = 2 * (n - 1);
      r   = k % per;
      return (r < n) ? r : per - r;
    end else if (m == 2'd1) begin
      return k % n;
    end
    return k;
  endfunction

  task automatic scramble;
    mode     = 2'($urandom);
    f_start  = 16'($urandom);
    f_step   = 16'($urandom);
    n_points = 16'($urandom);
    dwell    = 16'($urandom);
  endtask

  // continuous modes run ncyc cycles then abort; single-like modes run to done
  task automatic sweep(input string tag, input logic [1:0] m, input logic [15:0] fs,
                       input logic [15:0] st, input logic [15:0] n, input logic [15:0] d,
                       input int ncyc);
    int neff, deff, total, ix;
    logic [15:0] ph;
    bit cont;
    neff = (n == 0) ? 1 : int'(n);
    deff = (d == 0) ? 1 : int'(d);
    cont = (m == 2'd1) || (m == 2'd2);
    total = cont ? ncyc : neff * deff;
    ph = fs;
    ix = 0;
    mode = m; f_start = fs; f_step = st; n_points = n; dwell = d;
    start = 1'b1; abort = 1'b0;
    tick;
    for (int t = 1; t <= total; t++) begin
      ix = exp_idx(m, neff, (t - 1) / deff);
      ph = fs + 16'(ix) * st;
      chk_out({tag, ".run"}, 1'b1, 1'b1, 1'b0, ph, 16'(ix));
      if (t < total) begin
        start = 1'($urandom);
        scramble();
        tick;
      end
    end
    if (cont) begin
      abort = 1'b1; start = 1'b0;
      tick;
      abort = 1'b0;
      chk_out({tag, ".abort"}, 1'b0, 1'b0, 1'b0, ph, 16'(ix));
    end else begin
      start = 1'($urandom);
      tick;
      chk_out({tag, ".finish"}, 1'b0, 1'b0, 1'b1, ph, 16'(ix));
      start = 1'b1;
      tick;
      start = 1'b0;
      chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, ph, 16'(ix));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    mode = 2'd0; f_start = 16'h0; f_step = 16'h0; n_points = 16'h0; dwell = 16'h0;
    tick;
    tick;
    rst = 1'b0;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    sweep("single",  2'd0, 16'h051E, 16'h0100, 16'd4, 16'd3, 0);
    sweep("wrap",    2'd0, 16'hFF00, 16'h0200, 16'd2, 16'd1, 0);
    sweep("negstep", 2'd0, 16'h0005, 16'hFFF0, 16'd2, 16'd1, 0);
    sweep("tri",     2'd2, 16'h0000, 16'h0010, 16'd3, 16'd1, 12);
    sweep("repeat",  2'd1, 16'h0000, 16'h0010, 16'd3, 16'd1, 12);
    sweep("tri_n1",  2'd2, 16'h4321, 16'h0007, 16'd1, 16'd2, 6);
    sweep("degen",   2'd0, 16'h1234, 16'h0101, 16'd0, 16'd0, 0);
    sweep("mode3",   2'd3, 16'h0100, 16'h0001, 16'd3, 16'd2, 0);

    // abort during the second point of the single-sweep config
    mode = 2'd0; f_start = 16'h051E; f_step = 16'h0100; n_points = 16'd4; dwell = 16'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    chk_out("pre_abort", 1'b1, 1'b1, 1'b0, 16'h061E, 16'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk_out("abort", 1'b0, 1'b0, 1'b0, 16'h061E, 16'd1);
    tick;
    chk_out("abort_hold", 1'b0, 1'b0, 1'b0, 16'h061E, 16'd1);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    chk_out("contend", 1'b0, 1'b0, 1'b0, 16'h061E, 16'd1);
    tick;
    chk_out("contend2", 1'b0, 1'b0, 1'b0, 16'h061E, 16'd1);

    // reset mid-sweep, then a clean restart
    mode = 2'd1; f_start = 16'h0AAA; f_step = 16'h0011; n_points = 16'd5; dwell = 16'd2;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick;
    chk_out("rst_hold", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    sweep("after_rst", 2'd0, 16'h0AAA, 16'h0011, 16'd3, 16'd2, 0);

    for (int i = 0; i < 20; i++) begin
      sweep("rand", 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
            16'($urandom_range(0, 5)), 16'($urandom_range(0, 4)),
            int'($urandom_range(5, 30)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer that drives the CORDICNCO phase-increment input to produce stepped-frequency sweeps: single chirp, repeating sawtooth, or triangle up/down.
It holds each frequency point for a programmable dwell, steps phase_inc by a signed delta, and asserts val_o while the NCO must run.
It sits between the register/control layer and CORDICNCO (val_o -> val_i, phase_inc_o -> phase_inc_i).

Parameters:
PHASE_W, 16, width of phase increment (matches CORDICNCO phase_inc_i)
CNT_W, 16, width of point count and step index
DWELL_W, 16, width of dwell counter

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start request, sampled in IDLE only
abort_i  in  1  stop sweep immediately, no done pulse
mode_i  in  2  0=single, 1=repeat sawtooth, 2=triangle, 3=reserved (treated as single)
f_start_i  in  PHASE_W  first phase increment
f_step_i  in  PHASE_W  signed two's-complement increment per point
n_points_i  in  CNT_W  number of frequency points; 0 treated as 1
dwell_i  in  DWELL_W  clock cycles per point; 0 treated as 1
val_o  out  1  NCO enable
phase_inc_o  out  PHASE_W  phase increment to NCO
step_idx_o  out  CNT_W  index of current point (0..n_points-1)
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse at end of single sweep

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE. val_o, busy_o and done_o are 0. phase_inc_o and step_idx_o are 0. Internal counters and latched config are 0.
- Reset overrides everything, including mid-sweep; the NCO sees val_o=0 on the next cycle.
- States:
  - IDLE: waits for start.
  - RUN: outputs the current point.
  - FINISH: lasts exactly one cycle.
- IDLE -> RUN: start_i=1 and abort_i=0 at edge E0.
  - All config inputs are latched at E0 and are ignored afterwards.
  - After E0: val_o=1, busy_o=1, phase_inc_o=f_start, step_idx_o=0, dwell counter loaded.
  - Latency from start to first valid point is 1 cycle.
- RUN:
  - Each point is held for exactly dwell_eff cycles.
  - On the last dwell cycle of a point, the next point is computed: phase_inc_o += f_step, or -= in triangle-down.
  - Addition wraps modulo 2^PHASE_W with no saturation.
  - step_idx_o is incremented or decremented accordingly.
  - Adjacent points have no gap cycles.
- End of the last point (index n_eff-1, or index 0 when descending):
  - single: -> FINISH.
  - repeat: phase_inc_o reloads f_start and step_idx_o reloads 0; val_o stays 1.
  - triangle: direction reverses and the sweep continues with the next point inward. The endpoints are not repeated (0,1,2,1,0,1...). With n_eff=1 the point is constant.
- FINISH:
  - val_o=0, busy_o=0, done_o=1 for one cycle.
  - phase_inc_o and step_idx_o hold their last values.
  - start_i is ignored in this cycle; next state is IDLE.
- abort_i=1 in RUN: next cycle is IDLE with val_o=0 and busy_o=0; done_o stays 0; phase_inc_o holds.
- abort_i in IDLE has no effect. start_i and abort_i both high in IDLE: abort wins and the sweep does not start.
- start_i in RUN or FINISH is ignored. Repeat and triangle run until abort_i or reset.

Decomposition:
- Package nco_ctrl_pkg holds:
  - state enum (ST_IDLE, ST_RUN, ST_FINISH);
  - mode constants (MODE_SINGLE, MODE_REPEAT, MODE_TRIANGLE);
  - default widths.
- One sub-module, nco_dwell_timer: a loadable down-counter with a terminal-count flag. It handles dwell=0 by treating it as 1.
- The point/direction logic stays in the top module.

Test Plan:
- Single sweep: f_start=0x051E, f_step=0x0100, n=4, dwell=3, mode=0.
  - Required: val_o high for 12 cycles after E0.
  - phase_inc_o = 0x051E x3, 0x061E x3, 0x071E x3, 0x081E x3.
  - step_idx_o = 0..3.
  - Then done_o=1 for one cycle, with phase_inc_o=0x081E and val_o=0.
- Wrap and negative step: f_start=0xFF00, f_step=0x0200, n=2, dwell=1 gives 0xFF00, 0x0100. Then f_step=0xFFF0 (-16) from 0x0005 gives 0x0005, 0xFFF5.
- Triangle: f_start=0, f_step=0x0010, n=3, dwell=1, mode=2.
  - Required: phase_inc_o = 0, 0x10, 0x20, 0x10, 0, 0x10, 0x20...
  - step_idx_o = 0,1,2,1,0,1,2; done_o never asserts.
  - Repeat mode with the same config gives 0, 0x10, 0x20, 0, 0x10...
- Degenerate: n=0, dwell=0, mode=0 gives val_o=1 for one cycle at f_start, then the done_o pulse.
- Abort and contention:
  - abort_i during the 2nd point of the single-sweep config: next cycle val_o=0, busy_o=0, done_o=0.
  - start_i during RUN: ignored.
  - start_i and abort_i together in IDLE: stays IDLE.
- Reset mid-sweep: rst_i=1 for one cycle during RUN gives all outputs 0 at the next edge. A subsequent start_i begins cleanly from f_start with step_idx_o=0.
